// File: rtl/dedicated_datapath.sv
// Register-transfer datapath for the dedicated-processor controller:
// 8-entry register file, 4-function ALU, unsigned compare, output FIFO.
module dedicated_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RFSrcMuxSel,
    input  logic [2:0]                    RAddr1,
    input  logic [2:0]                    RAddr2,
    input  logic [2:0]                    WAddr,
    input  logic                          we,
    input  logic                          OutPortEn,
    input  logic [1:0]                    ALUop,
    output logic                          lte,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         OutPort,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] rf_q [8];
    logic [DATA_WIDTH-1:0] rf_d [8];
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] wdata;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] outport_q, outport_d;
    logic                  overflow_q, overflow_d;

    logic push, pop, full, accept;

    // Entry 0 is never written, so it reads as zero without a special mux.
    assign rdata1 = rf_q[RAddr1];
    assign rdata2 = rf_q[RAddr2];
    assign lte    = (rdata1 <= rdata2);

    always_comb begin
        unique case (ALUop)
            2'd0: alu_res = rdata1 + rdata2;
            2'd1: alu_res = rdata1 - rdata2;
            2'd2: alu_res = rdata1 & rdata2;
            2'd3: alu_res = rdata1 | rdata2;
        endcase
    end

    assign wdata = RFSrcMuxSel ? DATA_WIDTH'(1) : alu_res;

    always_comb begin
        rf_d = rf_q;
        if (we && (WAddr != 3'd0)) begin
            rf_d[WAddr] = wdata;
        end
        rf_d[0] = '0;
    end

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign push   = OutPortEn;
    assign pop    = out_valid && out_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign accept = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        outport_d  = outport_q;
        overflow_d = overflow_q;
        if (push) begin
            outport_d = rdata1;
        end
        if (accept) begin
            mem_d[wr_ptr_q] = rdata1;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else if (push) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q       <= '{default: '0};
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            outport_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            outport_q  <= outport_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_count = cnt_q;
    assign OutPort   = outport_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dedicated_datapath.sv
// Directed bench for dedicated_datapath with a register-file model
// and a FIFO scoreboard queue.
module tb_dedicated_datapath;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          RFSrcMuxSel;
    logic [2:0]    RAddr1, RAddr2, WAddr;
    logic          we, OutPortEn;
    logic [1:0]    ALUop;
    logic          lte;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] OutPort;
    logic [2:0]    out_count;
    logic          overflow;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] m [8];
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_outport;
    logic          m_ovf;

    dedicated_datapath #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .RFSrcMuxSel(RFSrcMuxSel),
        .RAddr1(RAddr1), .RAddr2(RAddr2), .WAddr(WAddr),
        .we(we), .OutPortEn(OutPortEn), .ALUop(ALUop),
        .lte(lte), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .OutPort(OutPort),
        .out_count(out_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic src, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [2:0] wa,
                       input logic w, input logic en,
                       input logic [1:0] op, input logic rdy);
        RFSrcMuxSel = src; RAddr1 = a1; RAddr2 = a2; WAddr = wa;
        we = w; OutPortEn = en; ALUop = op; out_ready = rdy;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = '0;
        q.delete();
        m_outport = '0;
        m_ovf = 1'b0;
    endtask

    // One clock: pre-edge checks and model update, post-edge checks.
    task automatic tick();
        logic [DW-1:0] a, b, r, w, e;
        a = m[RAddr1];
        b = m[RAddr2];
        chk("lte", 32'(lte), 32'(a <= b));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0 && out_ready) begin
            e = q.pop_front();
            chk("pop_data", 32'(out_data), 32'(e));
        end
        case (ALUop)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        w = RFSrcMuxSel ? 8'd1 : r;
        if (OutPortEn) begin
            m_outport = a;
            if (q.size() < DEPTH) q.push_back(a);
            else m_ovf = 1'b1;
        end
        if (we && WAddr != 3'd0) m[WAddr] = w;
        @(posedge clk);
        #1;
        chk("out_count", 32'(out_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("OutPort", 32'(OutPort), 32'(m_outport));
    endtask

    task automatic reset_checks();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_outport", 32'(OutPort), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_lte", 32'(lte), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        reset_checks();
        chk("rst_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // constant load, R0 write ignored
        set(1, 0, 0, 1, 1, 0, 0, 1); tick();
        set(1, 0, 0, 0, 1, 0, 0, 1); tick();
        set(0, 1, 0, 0, 0, 1, 0, 1); tick();
        chk("r1_const", 32'(OutPort), 32'd1);
        set(0, 0, 0, 0, 0, 1, 0, 1); tick();
        chk("r0_zero", 32'(OutPort), 32'd0);

        // ALU ops with wrap
        set(0, 1, 1, 2, 1, 0, 0, 1); tick();
        set(0, 1, 2, 3, 1, 0, 1, 1); tick();
        set(0, 2, 3, 4, 1, 0, 2, 1); tick();
        set(0, 2, 3, 5, 1, 0, 3, 1); tick();
        set(0, 2, 0, 0, 0, 1, 0, 1); tick();
        chk("add", 32'(OutPort), 32'h02);
        set(0, 3, 0, 0, 0, 1, 0, 1); tick();
        chk("sub_wrap", 32'(OutPort), 32'hFF);
        set(0, 4, 0, 0, 0, 1, 0, 1); tick();
        chk("and", 32'(OutPort), 32'h02);
        set(0, 5, 0, 0, 0, 1, 0, 1); tick();
        chk("or", 32'(OutPort), 32'hFF);

        // compare-only words
        set(0, 3, 2, 0, 0, 0, 0, 1);
        chk("lte_r3_r2", 32'(lte), 32'd0);
        set(0, 2, 3, 0, 0, 0, 0, 1);
        chk("lte_r2_r3", 32'(lte), 32'd1);
        set(0, 2, 2, 0, 0, 0, 0, 1);
        chk("lte_r2_r2", 32'(lte), 32'd1);
        tick();

        // same-address read/write
        set(0, 2, 1, 2, 1, 1, 0, 1); tick();
        chk("rw_old", 32'(OutPort), 32'd2);
        set(0, 2, 0, 0, 0, 1, 0, 1); tick();
        chk("rw_new", 32'(OutPort), 32'd3);
        set(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick();

        // load 1..5 into R1..R5, then fill past full
        set(0, 1, 1, 2, 1, 0, 0, 1); tick();
        set(0, 2, 1, 3, 1, 0, 0, 1); tick();
        set(0, 2, 2, 4, 1, 0, 0, 1); tick();
        set(0, 4, 1, 5, 1, 0, 0, 1); tick();
        for (int i = 1; i <= 5; i++) begin
            set(0, 3'(i), 0, 0, 0, 1, 0, 0); tick();
        end
        chk("fill_count", 32'(out_count), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_outport", 32'(OutPort), 32'd5);
        for (int i = 1; i <= 4; i++) begin
            set(0, 0, 0, 0, 0, 0, 0, 1);
            chk("drain_head", 32'(out_data), 32'(i));
            tick();
        end
        chk("drain_valid", 32'(out_valid), 32'd0);

        // fresh start: simultaneous push/pop at full
        reset = 1'b1;
        #1;
        model_clear();
        reset_checks();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set(1, 0, 0, 1, 1, 0, 0, 0); tick();
        set(0, 1, 1, 2, 1, 0, 0, 0); tick();
        set(0, 2, 1, 3, 1, 0, 0, 0); tick();
        set(0, 2, 2, 4, 1, 0, 0, 0); tick();
        set(0, 4, 4, 5, 1, 0, 0, 0); tick();
        set(0, 5, 1, 5, 1, 0, 0, 0); tick();
        for (int i = 1; i <= 4; i++) begin
            set(0, 3'(i), 0, 0, 0, 1, 0, 0); tick();
        end
        chk("full_count", 32'(out_count), 32'd4);
        set(0, 5, 0, 0, 0, 1, 0, 1); tick();
        chk("pp_count", 32'(out_count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_outport", 32'(OutPort), 32'd9);
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 0, 0, 0, 0, 0, 1);
            case (i)
                0: chk("pp_head", 32'(out_data), 32'd2);
                1: chk("pp_head", 32'(out_data), 32'd3);
                2: chk("pp_head", 32'(out_data), 32'd4);
                default: chk("pp_head", 32'(out_data), 32'd9);
            endcase
            tick();
        end
        chk("pp_valid", 32'(out_valid), 32'd0);

        // reset mid-run with R3=7 and two queued entries
        set(0, 3, 4, 3, 1, 0, 0, 0); tick();
        set(0, 1, 0, 0, 0, 1, 0, 0); tick();
        set(0, 2, 0, 0, 0, 1, 0, 0); tick();
        chk("pre_count", 32'(out_count), 32'd2);
        set(0, 3, 0, 0, 0, 0, 0, 0);
        chk("pre_lte_r3", 32'(lte), 32'd0);
        reset = 1'b1;
        #1;
        model_clear();
        reset_checks();
        chk("rst_data_mid", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set(0, 3, 0, 0, 0, 1, 0, 1); tick();
        chk("r3_cleared", 32'(OutPort), 32'd0);
        set(0, 0, 0, 0, 0, 0, 0, 1); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
